// File: rtl/spi_master_tx_multi.sv
// SPI master transmit shifter: single/dual/quad lanes, MSB- or LSB-first.
// Pulls words from a valid/ready FIFO port and shifts them out on tx_edge.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   en, tx_edge     shift enable and one-clk shift strobe
//   start, abort    begin a transfer / return to IDLE at once
//   mode, lsb_first lane mode and bit order, latched at start
//   bit_count       total bits of the transfer, latched at start
//   data, data_valid, data_ready   TX word handshake (ready is combinational)
//   sdo, sdo_oe     lane data and lane output enables
//   busy, tx_done, underrun        status, done/underrun are one-clk pulses
module spi_master_tx_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  tx_edge,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic                  lsb_first,
    input  logic [CNT_WIDTH-1:0]  bit_count,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [3:0]            sdo,
    output logic [3:0]            sdo_oe,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  underrun
);

    localparam int WB_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [WB_W-1:0] WB_ONE = 1;
    localparam logic [CNT_WIDTH:0] EXT_ONE = 1;
    localparam logic [CNT_WIDTH:0] EXT_THREE = 3;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STALL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] sr;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic [CNT_WIDTH-1:0]  target;
    logic [WB_W-1:0]       word_beat;
    logic [WB_W-1:0]       bpw_last;
    logic [1:0]            mode_q;
    logic [1:0]            rem_q;
    logic                  lsb_q;

    logic                  step;
    logic                  last_beat;
    logic                  word_end;
    logic                  go;
    logic [1:0]            mode_in;
    logic [CNT_WIDTH-1:0]  tgt_in;
    logic [1:0]            rem_in;
    logic [CNT_WIDTH:0]    sum1;
    logic [CNT_WIDTH:0]    sum3;
    logic [3:0]            raw;
    logic [3:0]            mask;

    assign step      = tx_edge & en;
    assign last_beat = (beat_cnt == target - CNT_ONE);
    assign word_end  = (word_beat == bpw_last);
    assign go        = start && (bit_count != '0);

    // Reserved mode 11 behaves as single lane.
    assign mode_in = (mode == 2'b11) ? 2'b00 : mode;
    assign sum1    = {1'b0, bit_count} + EXT_ONE;
    assign sum3    = {1'b0, bit_count} + EXT_THREE;

    // Beat target is ceil(bit_count/L); rem_in is the lane count used
    // by a partial final beat (0 when the final beat is full).
    always_comb begin
        tgt_in = bit_count;
        rem_in = 2'b00;
        case (mode_in)
            2'b01: begin
                tgt_in = sum1[CNT_WIDTH:1];
                rem_in = {1'b0, bit_count[0]};
            end
            2'b10: begin
                tgt_in = {1'b0, sum3[CNT_WIDTH:2]};
                rem_in = bit_count[1:0];
            end
            default: begin
                tgt_in = bit_count;
                rem_in = 2'b00;
            end
        endcase
    end

    always_comb begin
        case (mode_q)
            2'b01:   bpw_last = WB_W'(DATA_WIDTH / 2 - 1);
            2'b10:   bpw_last = WB_W'(DATA_WIDTH / 4 - 1);
            default: bpw_last = WB_W'(DATA_WIDTH - 1);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (go) state_nxt = LOAD;
                LOAD:  if (data_valid) state_nxt = SHIFT;
                SHIFT: begin
                    if (step) begin
                        if (last_beat) begin
                            state_nxt = IDLE;
                        end else if (word_end && !data_valid) begin
                            state_nxt = STALL;
                        end
                    end
                end
                STALL: if (data_valid) state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        data_ready = 1'b0;
        tx_done    = 1'b0;
        underrun   = 1'b0;
        busy       = (state != IDLE);
        sdo_oe     = 4'b0000;
        if (!abort) begin
            case (state)
                LOAD, STALL: data_ready = data_valid;
                SHIFT: begin
                    if (step) begin
                        tx_done    = last_beat;
                        data_ready = !last_beat && word_end && data_valid;
                        underrun   = !last_beat && word_end && !data_valid;
                    end
                end
                default: ;
            endcase
        end
        if (state != IDLE) begin
            case (mode_q)
                2'b01:   sdo_oe = 4'b0011;
                2'b10:   sdo_oe = 4'b1111;
                default: sdo_oe = 4'b0001;
            endcase
        end
    end

    // Lane mapping plus zeroing of unused positions on a partial last beat.
    // STALL is excluded from masking so the held value stays as driven.
    always_comb begin
        raw  = 4'b0000;
        mask = 4'b1111;
        if (lsb_q) begin
            case (mode_q)
                2'b01:   raw = {2'b00, sr[1:0]};
                2'b10:   raw = sr[3:0];
                default: raw = {3'b000, sr[0]};
            endcase
        end else begin
            case (mode_q)
                2'b01:   raw = {2'b00, sr[DATA_WIDTH-1], sr[DATA_WIDTH-2]};
                2'b10:   raw = sr[DATA_WIDTH-1:DATA_WIDTH-4];
                default: raw = {3'b000, sr[DATA_WIDTH-1]};
            endcase
        end
        if (state == SHIFT && last_beat && rem_q != 2'b00) begin
            if (lsb_q) begin
                case (rem_q)
                    2'b01:   mask = 4'b0001;
                    2'b10:   mask = 4'b0011;
                    default: mask = 4'b0111;
                endcase
            end else if (mode_q == 2'b10) begin
                case (rem_q)
                    2'b01:   mask = 4'b1000;
                    2'b10:   mask = 4'b1100;
                    default: mask = 4'b1110;
                endcase
            end else begin
                mask = 4'b0010;
            end
        end
        sdo = (state == SHIFT || state == STALL) ? (raw & mask) : 4'b0000;
    end

    // Datapath: configuration, counters and shift register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr        <= '0;
            beat_cnt  <= '0;
            word_beat <= '0;
            target    <= '0;
            mode_q    <= 2'b00;
            rem_q     <= 2'b00;
            lsb_q     <= 1'b0;
        end else if (abort) begin
            sr        <= '0;
            beat_cnt  <= '0;
            word_beat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        mode_q    <= mode_in;
                        lsb_q     <= lsb_first;
                        target    <= tgt_in;
                        rem_q     <= rem_in;
                        beat_cnt  <= '0;
                        word_beat <= '0;
                    end
                end
                LOAD: begin
                    if (data_valid) begin
                        sr        <= data;
                        word_beat <= '0;
                    end
                end
                SHIFT: begin
                    if (step && !last_beat) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (word_end) begin
                            word_beat <= '0;
                            if (data_valid) sr <= data;
                        end else begin
                            word_beat <= word_beat + WB_ONE;
                            case ({lsb_q, mode_q})
                                3'b001:  sr <= {sr[DATA_WIDTH-3:0], 2'b00};
                                3'b010:  sr <= {sr[DATA_WIDTH-5:0], 4'b0000};
                                3'b101:  sr <= {2'b00, sr[DATA_WIDTH-1:2]};
                                3'b110:  sr <= {4'b0000, sr[DATA_WIDTH-1:4]};
                                3'b100:  sr <= {1'b0, sr[DATA_WIDTH-1:1]};
                                default: sr <= {sr[DATA_WIDTH-2:0], 1'b0};
                            endcase
                        end
                    end
                end
                STALL: begin
                    if (data_valid) sr <= data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx_multi.sv
// Self-checking bench for spi_master_tx_multi.
// Expected lane beats come from a bit-stream model pushed to a queue at start.
module tb_spi_master_tx_multi;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        tx_edge;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic        lsb_first;
    logic [15:0] bit_count;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  sdo;
    logic [3:0]  sdo_oe;
    logic        busy;
    logic        tx_done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq[$];
    logic [31:0] snap[$];
    logic [3:0]  exp_q[$];

    spi_master_tx_multi #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge),
        .start(start), .abort(abort), .mode(mode),
        .lsb_first(lsb_first), .bit_count(bit_count), .data(data),
        .data_valid(data_valid), .data_ready(data_ready), .sdo(sdo),
        .sdo_oe(sdo_oe), .busy(busy), .tx_done(tx_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream bit s of the transfer lands on lane L-1-j (MSB-first) or j.
    function automatic logic [3:0] exp_beat(int b, int nl, bit l, int bc);
        logic [3:0]  r;
        logic [31:0] w;
        int s;
        r = '0;
        for (int j = 0; j < nl; j++) begin
            s = b * nl + j;
            if (s < bc) begin
                w = snap[s / 32];
                r[l ? j : nl - 1 - j] = l ? w[s % 32] : w[31 - (s % 32)];
            end
        end
        return r;
    endfunction

    task automatic xfer(input logic [1:0] m, input bit l, input int bc,
                        input int stall_n, output int done_edge,
                        output int n_rdy, output int rdy_edge,
                        output int und_edge);
        int nl, tgt, edge_n, cyc_n;
        bit stalled, resumed, finished;
        logic [3:0] last_sdo, exp_oe, e;
        nl = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        tgt = (bc + nl - 1) / nl;
        exp_oe = (nl == 4) ? 4'hF : (nl == 2) ? 4'h3 : 4'h1;
        snap = wq;
        for (int b = 0; b < tgt; b++) exp_q.push_back(exp_beat(b, nl, l, bc));
        done_edge = -1; n_rdy = 0; rdy_edge = -1; und_edge = -1;
        edge_n = 0; last_sdo = '0;
        mode = m; lsb_first = l; bit_count = 16'(bc);
        start = 1'b1; data_valid = 1'b0; tx_edge = 1'b0; en = 1'b1;
        #1;
        cyc();
        start = 1'b0; mode = ~m; lsb_first = ~l; bit_count = 16'hFFFF;
        data = wq[0]; data_valid = 1'b1;
        #1;
        chk("load_ready", data_ready, 1);
        chk("load_busy", busy, 1);
        cyc();
        void'(wq.pop_front());
        n_rdy = 1;
        finished = 0; stalled = 0; resumed = 0; cyc_n = 0;
        while (!finished && cyc_n < 400) begin
            cyc_n++;
            en = 1'b0; tx_edge = 1'b1; data_valid = 1'b0;
            #1;
            chk("gap_done", tx_done, 0);
            cyc();
            en = 1'b1;
            if (!stalled) begin
                data_valid = !(stall_n > 0 && !resumed) && wq.size() > 0;
                data = (wq.size() > 0) ? wq[0] : '0;
                tx_edge = 1'b1;
                #1;
                edge_n++;
                if (exp_q.size() == 0) e = 4'hx;
                else e = exp_q.pop_front();
                chk("sdo", sdo, e);
                chk("sdo_oe", sdo_oe, exp_oe);
                last_sdo = sdo;
                if (data_ready) begin
                    n_rdy++;
                    rdy_edge = edge_n;
                    if (wq.size() > 0) void'(wq.pop_front());
                end
                if (underrun) begin
                    und_edge = edge_n;
                    stalled = 1;
                end
                if (tx_done) begin
                    done_edge = edge_n;
                    finished = 1;
                end
                cyc();
                tx_edge = 1'b0;
            end else begin
                for (int k = 0; k < stall_n; k++) begin
                    tx_edge = 1'b1; data_valid = 1'b0;
                    #1;
                    chk("stall_sdo", sdo, last_sdo);
                    chk("stall_flags", {data_ready, underrun, tx_done}, 0);
                    cyc();
                end
                tx_edge = 1'b0; data_valid = 1'b1;
                data = (wq.size() > 0) ? wq[0] : '0;
                #1;
                chk("resume_ready", data_ready, 1);
                if (data_ready) begin
                    n_rdy++;
                    if (wq.size() > 0) void'(wq.pop_front());
                end
                cyc();
                resumed = 1;
                stalled = 0;
            end
        end
        chk("no_timeout", finished, 1);
        tx_edge = 1'b0; data_valid = 1'b0;
        #1;
        chk("end_busy", busy, 0);
        chk("end_oe", sdo_oe, 0);
        chk("end_sdo", sdo, 0);
        chk("beats_left", exp_q.size(), 0);
        exp_q.delete();
        wq.delete();
    endtask

    initial begin
        int de, nr, re, ue;
        rstn = 1'b0; en = 1'b0; tx_edge = 1'b0; start = 1'b0;
        abort = 1'b0; mode = 2'b00; lsb_first = 1'b0;
        bit_count = '0; data = '0; data_valid = 1'b1;
        #12;
        chk("rst_sdo", sdo, 0);
        chk("rst_oe", sdo_oe, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_flags", {busy, tx_done, underrun}, 0);
        data_valid = 1'b0;
        rstn = 1'b1;
        cyc();

        // Single, MSB-first, one byte; a spare word stays valid at the end
        wq = '{32'hA500_0000, 32'hDEAD_BEEF};
        xfer(2'b00, 1'b0, 8, 0, de, nr, re, ue);
        chk("t1_done_edge", de, 8);
        chk("t1_ready_cnt", nr, 1);

        // Quad, two words
        wq = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_5555};
        xfer(2'b10, 1'b0, 64, 0, de, nr, re, ue);
        chk("t2_done_edge", de, 16);
        chk("t2_ready_cnt", nr, 2);
        chk("t2_ready_edge", re, 8);

        // Dual, LSB-first, 6 bits
        wq = '{32'h0000_002D, 32'hFFFF_FFFF};
        xfer(2'b01, 1'b1, 6, 0, de, nr, re, ue);
        chk("t3_done_edge", de, 3);
        chk("t3_ready_cnt", nr, 1);

        // Single, 40 bits, FIFO runs dry after the first word
        wq = '{32'hC3A5_0F96, 32'h6B00_0000, 32'h1111_1111};
        xfer(2'b00, 1'b0, 40, 3, de, nr, re, ue);
        chk("t4_under_edge", ue, 32);
        chk("t4_ready_cnt", nr, 2);
        chk("t4_done_edge", de, 40);

        // Quad, partial final beat
        wq = '{32'hABCD_EF12, 32'h7777_7777};
        xfer(2'b10, 1'b0, 10, 0, de, nr, re, ue);
        chk("t5_done_edge", de, 3);

        // Quad, LSB-first, partial final beat of 3 lanes
        wq = '{32'h8765_4321, 32'h0};
        xfer(2'b10, 1'b1, 7, 0, de, nr, re, ue);
        chk("t5b_done_edge", de, 2);

        // Reserved mode runs as single lane
        wq = '{32'h3C00_0000, 32'h0};
        xfer(2'b11, 1'b0, 8, 0, de, nr, re, ue);
        chk("rsv_done_edge", de, 8);

        // Zero-length start is ignored
        mode = 2'b00; bit_count = '0; start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("zero_len_busy", busy, 0);

        // Abort at beat 5 together with a start pulse
        snap = '{32'hF0F0_1234};
        mode = 2'b00; lsb_first = 1'b0; bit_count = 16'd32; start = 1'b1;
        cyc();
        start = 1'b0; data = 32'hF0F0_1234; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; tx_edge = 1'b1;
            #1;
            chk("ab_sdo", sdo, exp_beat(i, 1, 1'b0, 32));
            cyc();
        end
        abort = 1'b1; start = 1'b1; tx_edge = 1'b1; data_valid = 1'b1;
        #1;
        chk("ab_done", tx_done, 0);
        chk("ab_ready", data_ready, 0);
        cyc();
        abort = 1'b0; start = 1'b0; tx_edge = 1'b0; data_valid = 1'b0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_sdo0", sdo, 0);
        chk("ab_oe0", sdo_oe, 0);
        tx_edge = 1'b1;
        cyc();
        cyc();
        tx_edge = 1'b0;
        #1;
        chk("ab_still_idle", busy, 0);

        wq = '{32'h9E37_79B9, 32'h0};
        xfer(2'b00, 1'b0, 32, 0, de, nr, re, ue);
        chk("ab_rerun_done", de, 32);

        // Asynchronous reset in the middle of a transfer
        mode = 2'b10; bit_count = 16'd16; start = 1'b1;
        cyc();
        start = 1'b0; data = 32'hFFFF_FFFF; data_valid = 1'b1;
        cyc();
        tx_edge = 1'b1;
        cyc();
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_lanes", {sdo, sdo_oe}, 0);
        chk("mid_rst_ready", data_ready, 0);
        tx_edge = 1'b0; data_valid = 1'b0;
        #1;
        rstn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
